laundry_pump_arbiter: RTL and testbench

- Shares one drain pump / hot-water valve between NUM_MACHINES washing-machine controllers.
- Round-robin, one-hot grant; enforces a maximum hold time per owner and a valve-settling gap between owners.
- Forced releases return a one-cycle time_out pulse per machine, wired into each controller's Time_Out input.
- Pump fault input forces all grants off until the fault clears.

---
 rtl/laundry_pump_arbiter.sv | 143 ++++++++++++++
 tb/tb_laundry_pump_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/laundry_pump_arbiter.sv
// rtl/laundry_pump_arbiter.sv - round-robin pump/valve arbiter with hold limit, settling gap and fault lockout
// Optional PUMP_ARB_PRIORITY_EN adds a prio input that narrows arbitration to prioritised requesters.
module laundry_pump_arbiter #(
  parameter int NUM_MACHINES = 4,
  parameter int MAX_HOLD     = 32,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_MACHINES-1:0]         req,
  input  logic [NUM_MACHINES-1:0]         done,
`ifdef PUMP_ARB_PRIORITY_EN
  input  logic [NUM_MACHINES-1:0]         prio,
`endif
  input  logic                            pump_fault,
  output logic [NUM_MACHINES-1:0]         grant,
  output logic [$clog2(NUM_MACHINES)-1:0] owner,
  output logic                            busy,
  output logic [NUM_MACHINES-1:0]         time_out
);

  localparam int IW = $clog2(NUM_MACHINES);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, GRANT, GAP, FAULT} state_t;

  state_t                  state_q, state_d;
  logic [NUM_MACHINES-1:0] grant_q, grant_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic                    busy_q, busy_d;
  logic [NUM_MACHINES-1:0] time_out_q, time_out_d;
  logic [IW-1:0]           rr_q, rr_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [GW-1:0]           gap_q, gap_d;

  logic [NUM_MACHINES-1:0] cand;
  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           next_ptr;
  int                      scan_idx;
  state_t                  after_release;

  always_comb begin
`ifdef PUMP_ARB_PRIORITY_EN
    cand = ((req & prio) != '0) ? (req & prio) : req;
`else
    cand = req;
`endif
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_MACHINES; i++) begin
      scan_idx = (int'(rr_q) + i) % NUM_MACHINES;
      if (!pick_found && cand[IW'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(scan_idx);
      end
    end
  end

  assign next_ptr      = (owner_q == IW'(NUM_MACHINES - 1)) ? '0 : owner_q + IW'(1);
  assign after_release = (GAP_CYCLES > 0) ? GAP : IDLE;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    time_out_d = '0;
    rr_d       = rr_q;
    hold_d     = hold_q;
    gap_d      = gap_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_MACHINES'(1) << pick_idx;
          owner_d = pick_idx;
          hold_d  = HW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A release in the timeout cycle wins, so the owner sees no time_out.
        if (done[owner_q] || !req[owner_q] || (hold_q == HW'(MAX_HOLD))) begin
          if (!done[owner_q] && req[owner_q]) time_out_d[owner_q] = 1'b1;
          grant_d = '0;
          rr_d    = next_ptr;
          gap_d   = GW'(1);
          state_d = after_release;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q >= GW'(GAP_CYCLES)) state_d = IDLE;
        else                          gap_d   = gap_q + GW'(1);
      end
      FAULT: begin
        gap_d   = GW'(1);
        state_d = after_release;
      end
      default: state_d = IDLE;
    endcase

    if (pump_fault) begin
      state_d    = FAULT;
      grant_d    = '0;
      time_out_d = '0;
      rr_d       = rr_q;
    end

    busy_d = |grant_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      time_out_q <= '0;
      rr_q       <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      time_out_q <= time_out_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
    end
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign time_out = time_out_q;

endmodule

// File: tb/tb_laundry_pump_arbiter.sv
// tb/tb_laundry_pump_arbiter.sv - scoreboard bench for laundry_pump_arbiter (N=4, MAX_HOLD=8, GAP=2)
module tb_laundry_pump_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic       pump_fault = 1'b0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] time_out;
`ifdef PUMP_ARB_PRIORITY_EN
  logic [3:0] prio = '0;
`endif

  laundry_pump_arbiter #(.NUM_MACHINES(4), .MAX_HOLD(8), .GAP_CYCLES(2)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .done(done),
`ifdef PUMP_ARB_PRIORITY_EN
    .prio(prio),
`endif
    .pump_fault(pump_fault),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .time_out(time_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic [3:0] t;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.nm, ".grant"},    32'(grant),    32'(mon_e.g));
      chk({mon_e.nm, ".owner"},    32'(owner),    32'(mon_e.o));
      chk({mon_e.nm, ".busy"},     32'(busy),     32'(mon_e.b));
      chk({mon_e.nm, ".time_out"}, 32'(time_out), 32'(mon_e.t));
    end
  end

  // Drive one cycle of inputs, then queue the outputs expected after that edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] d, input logic f,
                      input logic [3:0] eg, input logic [1:0] eo, input logic [3:0] et,
                      input string nm);
    exp_t e;
    reset      = rst;
    req        = r;
    done       = d;
    pump_fault = f;
    @(posedge clock);
    #1;
    e.g  = eg;
    e.o  = eo;
    e.b  = (eg != 4'b0000);
    e.t  = et;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    int         ks[5];
    logic [3:0] oh;
    ks = '{0, 1, 2, 3, 0};

    step(1, 4'b1111, 0, 0, 4'b0000, 0, 0, "rst1");
    step(1, 4'b1111, 0, 0, 4'b0000, 0, 0, "rst2");

    step(0, 4'b0001, 0,       0, 4'b0001, 0, 0, "t2_g1");
    step(0, 4'b0001, 0,       0, 4'b0001, 0, 0, "t2_g2");
    step(0, 4'b0001, 0,       0, 4'b0001, 0, 0, "t2_g3");
    step(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, "t2_rel");
    step(0, 4'b0001, 0,       0, 4'b0000, 0, 0, "t2_gap1");
    step(0, 4'b0001, 0,       0, 4'b0000, 0, 0, "t2_gap2");
    step(0, 4'b0001, 0,       0, 4'b0001, 0, 0, "t2_regrant");
    step(0, 4'b0000, 0,       0, 4'b0000, 0, 0, "t2_reqdrop");
    step(0, 4'b0000, 0,       0, 4'b0000, 0, 0, "t2_gap1b");
    step(0, 4'b0000, 0,       0, 4'b0000, 0, 0, "t2_gap2b");
    step(1, 4'b0000, 0,       0, 4'b0000, 0, 0, "rst3");

    foreach (ks[i]) begin
      oh = 4'b0001 << ks[i];
      step(0, 4'b1111, 0,  0, oh,      2'(ks[i]), 0, "t3_g1");
      step(0, 4'b1111, 0,  0, oh,      2'(ks[i]), 0, "t3_g2");
      step(0, 4'b1111, oh, 0, 4'b0000, 2'(ks[i]), 0, "t3_rel");
      step(0, 4'b1111, 0,  0, 4'b0000, 2'(ks[i]), 0, "t3_gap1");
      step(0, 4'b1111, 0,  0, 4'b0000, 2'(ks[i]), 0, "t3_gap2");
    end

    for (int i = 0; i < 8; i++) step(0, 4'b0100, 0, 0, 4'b0100, 2, 0, "t4_hold");
    step(0, 4'b0100, 0, 0, 4'b0000, 2, 4'b0100, "t4_timeout");
    step(0, 4'b0100, 0, 0, 4'b0000, 2, 0,       "t4_gap1");
    step(0, 4'b0100, 0, 0, 4'b0000, 2, 0,       "t4_gap2");
    step(0, 4'b0100, 0, 0, 4'b0100, 2, 0,       "t4_regrant");
    step(0, 4'b0000, 0, 0, 4'b0000, 2, 0,       "t4_reqdrop");
    step(0, 4'b0000, 0, 0, 4'b0000, 2, 0,       "t4_gap1b");
    step(0, 4'b0000, 0, 0, 4'b0000, 2, 0,       "t4_gap2b");

    for (int i = 0; i < 4; i++) step(0, 4'b0010, 0, 0, 4'b0010, 1, 0, "t5_hold");
    step(0, 4'b0010, 0, 1, 4'b0000, 1, 0, "t5_fault");
    step(0, 4'b0010, 0, 1, 4'b0000, 1, 0, "t5_fault_hold");
    step(0, 4'b0010, 0, 0, 4'b0000, 1, 0, "t5_fault_clr");
    step(0, 4'b0010, 0, 0, 4'b0000, 1, 0, "t5_gap1");
    step(0, 4'b0010, 0, 0, 4'b0000, 1, 0, "t5_gap2");
    step(0, 4'b0010, 0, 0, 4'b0010, 1, 0, "t5_regrant");

    step(0, 4'b0010, 0,       0, 4'b0010, 1, 0, "t6_h2");
    step(0, 4'b0010, 4'b1000, 0, 4'b0010, 1, 0, "t6_foreign_done");
    for (int i = 0; i < 5; i++) step(0, 4'b0010, 0, 0, 4'b0010, 1, 0, "t6_hold");
    step(0, 4'b0010, 4'b0010, 0, 4'b0000, 1, 0, "t6_done_at_max");
    step(0, 4'b0010, 0,       0, 4'b0000, 1, 0, "t6_gap1");
    step(0, 4'b0010, 0,       0, 4'b0000, 1, 0, "t6_gap2");
    step(0, 4'b0010, 0,       0, 4'b0010, 1, 0, "t6_regrant");
    step(1, 4'b0010, 0,       0, 4'b0000, 0, 0, "t6_reset_mid");
    step(0, 4'b0000, 0,       0, 4'b0000, 0, 0, "t6_idle");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
